// File: rtl/uart_stream_tx_pkg.sv
// Shared constants for the UART stream blocks (TX today, RX later).
package uart_stream_tx_pkg;

    // Frame state encoding, fixed so a matching receiver can reuse it.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } uart_state_e;

    // Bit index within the data field; wide enough for up to 8 data bits.
    localparam int unsigned BIT_IDX_W = 3;

    // Counter width for a given bit period, never narrower than one bit.
    function automatic int unsigned timer_width(input int unsigned clocks_per_bit);
        return (clocks_per_bit > 1) ? $clog2(clocks_per_bit) : 1;
    endfunction

endpackage

// File: rtl/uart_stream_tx_bit_timer.sv
// Bit-period down-counter: emits a one-cycle expiry pulse every CLOCKS_PER_BIT
// cycles while running, restarting the period on an explicit load.
module bit_timer
    import uart_stream_tx_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic run,
    output logic expire
);

    localparam int unsigned CW = timer_width(CLOCKS_PER_BIT);
    localparam logic [CW-1:0] RELOAD = CW'(CLOCKS_PER_BIT - 1);

    logic [CW-1:0] count;

    // Reload on start of frame and at every bit boundary; park at zero when idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load || (run && (count == '0))) begin
            count <= RELOAD;
        end else if (run) begin
            count <= count - CW'(1);
        end else begin
            count <= '0;
        end
    end

    // Expiry marks the last cycle of the current bit period.
    always_comb begin
        expire = run && (count == '0);
    end

endmodule

// File: rtl/uart_stream_tx.sv
// Byte-stream to UART serial transmitter: 1 start bit, DATA_BITS data bits
// (LSB first), 1 stop bit, no parity. One idle cycle separates frames.
module uart_stream_tx
    import uart_stream_tx_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS      = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       tx,
    output logic       busy
);

    localparam logic [BIT_IDX_W-1:0] LAST_IDX = BIT_IDX_W'(DATA_BITS - 1);

    uart_state_e          state;
    logic [7:0]           shreg;
    logic [BIT_IDX_W-1:0] bit_idx;
    logic                 transfer;
    logic                 expire;

    // Handshake: ready only in IDLE and never while reset is held.
    always_comb begin
        in_ready = (state == StIdle) && !reset;
        transfer = in_valid && in_ready;
        busy     = (state != StIdle);
    end

    bit_timer #(
        .CLOCKS_PER_BIT (CLOCKS_PER_BIT)
    ) u_bit_timer (
        .clock  (clock),
        .reset  (reset),
        .load   (transfer),
        .run    (busy),
        .expire (expire)
    );

    // Frame FSM with registered tx; in_data is only sampled on the transfer edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= StIdle;
            tx      <= 1'b1;
            shreg   <= '0;
            bit_idx <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    tx <= 1'b1;
                    if (transfer) begin
                        state   <= StStart;
                        tx      <= 1'b0;
                        shreg   <= in_data;
                        bit_idx <= '0;
                    end
                end
                StStart: begin
                    if (expire) begin
                        state <= StData;
                        tx    <= shreg[0];
                    end
                end
                StData: begin
                    if (expire) begin
                        shreg <= shreg >> 1;
                        if (bit_idx == LAST_IDX) begin
                            state   <= StStop;
                            tx      <= 1'b1;
                            bit_idx <= '0;
                        end else begin
                            // Next bit is the one about to land in position 0.
                            tx      <= shreg[1];
                            bit_idx <= bit_idx + BIT_IDX_W'(1);
                        end
                    end
                end
                StStop: begin
                    if (expire) begin
                        state <= StIdle;
                        tx    <= 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_stream_tx.sv
// Scoreboard bench for uart_stream_tx with CLOCKS_PER_BIT=4, DATA_BITS=8.
module tb_uart_stream_tx;

    localparam int CPB = 4;

    logic       clock = 1'b0;
    logic       rst   = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       tx;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] data;
        int         gap;
    } exp_t;

    exp_t q[$];

    uart_stream_tx #(
        .CLOCKS_PER_BIT (CPB),
        .DATA_BITS      (8)
    ) dut (
        .clock    (clock),
        .reset    (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .tx       (tx),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Offer one byte; returns just after the accepting edge.
    task automatic send(input logic [7:0] b, input int gap, input bit hold, input bit expect_it);
        int n = 0;
        @(negedge clock);
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1) begin
            @(negedge clock);
            n++;
            if (n > 200) begin
                check("send_timeout", 0, 1);
                in_valid = 1'b0;
                return;
            end
        end
        if (expect_it) q.push_back('{data: b, gap: gap});
        @(posedge clock);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("idle_timeout", {31'd0, busy}, 0);
    endtask

    task automatic wait_n(input int n, output bit ab);
        ab = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (rst) ab = 1'b1;
        end
    endtask

    // Monitor: decode each frame at mid-bit and compare with the scoreboard.
    initial begin : monitor
        int         start_cyc;
        int         last_start;
        bit         ab;
        logic [7:0] bits;
        logic       stop_bit;
        exp_t       e;
        last_start = 0;
        forever begin
            @(negedge clock);
            if (!rst && tx === 1'b0) begin
                start_cyc = cyc;
                bits = '0;
                wait_n(2, ab);
                for (int i = 0; i < 8 && !ab; i++) begin
                    wait_n(CPB, ab);
                    bits[i] = tx;
                end
                stop_bit = 1'b0;
                if (!ab) begin
                    wait_n(CPB, ab);
                    stop_bit = tx;
                end
                if (!ab) begin
                    if (q.size() == 0) begin
                        check("unexpected_frame", {24'd0, bits}, 32'hFFFF_FFFF);
                    end else begin
                        e = q.pop_front();
                        check("frame_data", {24'd0, bits}, {24'd0, e.data});
                        check("stop_bit", {31'd0, stop_bit}, 1);
                        if (e.gap >= 0) check("frame_gap", start_cyc - last_start, e.gap);
                    end
                end
                last_start = start_cyc;
            end
        end
    end

    initial begin : stim
        logic seq[10];
        int   busy_cnt;
        int   n;
        seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        // Reset state.
        repeat (3) @(negedge clock);
        check("rst_tx", {31'd0, tx}, 1);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_ready", {31'd0, in_ready}, 0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", {31'd0, in_ready}, 1);

        // Single byte 0xA5, cycle-exact waveform.
        send(8'hA5, -1, 1'b0, 1'b1);
        busy_cnt = 0;
        for (int c = 0; c < 10 * CPB; c++) begin
            check($sformatf("a5_tx_c%0d", c), {31'd0, tx}, {31'd0, seq[c / CPB]});
            if (busy === 1'b1) busy_cnt++;
            @(posedge clock);
            #1;
        end
        check("a5_busy_len", busy_cnt, 40);
        check("a5_end_busy", {31'd0, busy}, 0);
        check("a5_end_tx", {31'd0, tx}, 1);

        // Back-to-back with in_valid held: 0x55 then 0x0F, 41 cycles apart.
        send(8'h55, -1, 1'b1, 1'b1);
        send(8'h0F, 41, 1'b0, 1'b1);
        wait_idle();

        // in_data/in_valid changes mid-frame must not disturb 0x00.
        send(8'h00, -1, 1'b0, 1'b1);
        repeat (10) @(posedge clock);
        #1;
        in_data  = 8'hFF;
        in_valid = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        in_valid = 1'b0;
        wait_idle();

        // Reset during data bit 3 aborts asynchronously.
        send(8'hC3, -1, 1'b0, 1'b0);
        repeat (17) @(posedge clock);
        #2;
        rst = 1'b1;
        #1;
        check("abort_tx", {31'd0, tx}, 1);
        check("abort_ready", {31'd0, in_ready}, 0);
        check("abort_busy", {31'd0, busy}, 0);
        repeat (3) @(negedge clock);
        #1;
        rst      = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h3C;
        q.push_back('{data: 8'h3C, gap: -1});
        #1;
        check("release_ready", {31'd0, in_ready}, 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        check("release_accept_busy", {31'd0, busy}, 1);
        check("release_accept_tx", {31'd0, tx}, 0);
        wait_idle();

        // Idle stall.
        for (int c = 0; c < 100; c++) begin
            @(negedge clock);
            check("stall_tx", {31'd0, tx}, 1);
            check("stall_busy", {31'd0, busy}, 0);
            check("stall_ready", {31'd0, in_ready}, 1);
        end

        // Streamed pair 0xAA, 0xBB in order.
        send(8'hAA, -1, 1'b1, 1'b1);
        send(8'hBB, 41, 1'b0, 1'b1);
        wait_idle();

        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        repeat (4) @(negedge clock);
        check("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
